aes_decrypt_ctrl: RTL and testbench

- Iterative AES inverse-cipher controller that sequences one shared decrypt-round datapath over NR rounds to turn a 128-bit ciphertext into plaintext.
- The datapath order is InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
- Round keys are fetched from an external round-key store with a 1-cycle synchronous read latency; keys are prefetched one cycle ahead.
- Sits between the block-level valid/ready stream interface and the key-schedule memory.

---
 rtl/aes_decrypt_ctrl.sv | 162 ++++++++++++++++
 tb/tb_aes_decrypt_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES inverse cipher: one shared decrypt-round datapath stepped over NR rounds,
// with round keys prefetched one cycle ahead from an external synchronous key store.
module aes_decrypt_ctrl #(
  parameter int NR     = 10,
  parameter int KEY_AW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              key_rd_en,
  output logic [KEY_AW-1:0] key_addr,
  input  logic [127:0]      key_data,
  output logic              busy,
  output logic [KEY_AW-1:0] round
);

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} stateT;

  localparam logic [KEY_AW-1:0] LastKey    = KEY_AW'(NR);
  localparam logic [KEY_AW-1:0] PenultKey  = KEY_AW'(NR - 1);
  localparam logic [31:0]       InvMixCoef = 32'h0e0b0d09;

  stateT              fsmReg, fsmNext;
  logic [127:0]       dataReg, dataNext;
  logic [127:0]       outReg, outNext;
  logic [KEY_AW-1:0]  roundReg, roundNext;
  logic [KEY_AW-1:0]  addrReg, addrNext;
  logic               issue;
  logic [127:0]       subBytes;
  logic [127:0]       addKey;
  logic [127:0]       mixCols;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Inverse affine map followed by the field inverse, computed as t^254.
  function automatic logic [7:0] invSbox(input logic [7:0] s);
    logic [7:0] t;
    logic [7:0] sq;
    logic [7:0] inv;
    t   = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    sq  = t;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    return inv;
  endfunction

  function automatic logic [31:0] invMixCol(input logic [31:0] c);
    logic [31:0] r;
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int k = 0; k < 4; k++)
        r[31-8*row -: 8] = r[31-8*row -: 8]
                         ^ gfMul(c[31-8*k -: 8], InvMixCoef[31-8*((k-row+4)%4) -: 8]);
    return r;
  endfunction

  // Byte gi sits at column gi/4, row gi%4; row r rotates right by r columns.
  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_sub
    localparam int Col     = gi / 4;
    localparam int Row     = gi % 4;
    localparam int SrcByte = 4 * ((Col - Row + 4) % 4) + Row;
    assign subBytes[127-8*gi -: 8] = invSbox(dataReg[127-8*SrcByte -: 8]);
  end

  assign addKey = subBytes ^ key_data;

  for (gi = 0; gi < 4; gi++) begin : g_mix
    assign mixCols[127-32*gi -: 32] = invMixCol(addKey[127-32*gi -: 32]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsmReg   <= IDLE;
      dataReg  <= '0;
      outReg   <= '0;
      roundReg <= '0;
      addrReg  <= '0;
    end else begin
      fsmReg   <= fsmNext;
      dataReg  <= dataNext;
      outReg   <= outNext;
      roundReg <= roundNext;
      addrReg  <= key_addr;
    end
  end

  always_comb begin
    fsmNext   = fsmReg;
    dataNext  = dataReg;
    outNext   = outReg;
    roundNext = roundReg;
    addrNext  = addrReg;
    issue     = 1'b0;
    case (fsmReg)
      IDLE: begin
        if (in_valid) begin
          dataNext  = in_data;
          roundNext = LastKey;
          addrNext  = LastKey;
          issue     = 1'b1;
          fsmNext   = INIT;
        end
      end
      INIT: begin
        dataNext  = dataReg ^ key_data;
        roundNext = PenultKey;
        addrNext  = PenultKey;
        issue     = 1'b1;
        fsmNext   = ROUND;
      end
      ROUND: begin
        dataNext  = mixCols;
        roundNext = roundReg - KEY_AW'(1);
        addrNext  = roundReg - KEY_AW'(1);
        issue     = 1'b1;
        if (roundReg == KEY_AW'(1)) fsmNext = FINAL;
      end
      FINAL: begin
        // Last round omits InvMixColumns; only this state moves the visible result.
        dataNext = addKey;
        outNext  = addKey;
        fsmNext  = DONE;
      end
      DONE: begin
        if (out_ready) fsmNext = IDLE;
      end
      default: fsmNext = IDLE;
    endcase
  end

  assign in_ready  = reset_n && (fsmReg == IDLE);
  assign key_rd_en = reset_n && issue;
  assign key_addr  = key_rd_en ? addrNext : addrReg;
  assign out_valid = (fsmReg == DONE);
  assign out_data  = outReg;
  assign busy      = (fsmReg != IDLE);
  assign round     = roundReg;

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Bench for aes_decrypt_ctrl: NR=10 and NR=14 instances against FIPS-197 vectors and a
// table-driven byte-level AES inverse cipher.
module tb_aes_decrypt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, inValid, outReady, useBig;
  logic [127:0] inData;

  logic         iv10, ir10, ov10, kr10, busy10;
  logic [127:0] od10, kd10;
  logic [3:0]   ka10, rd10;
  logic         iv14, ir14, ov14, kr14, busy14;
  logic [127:0] od14, kd14;
  logic [3:0]   ka14, rd14;

  assign iv10 = inValid && !useBig;
  assign iv14 = inValid && useBig;

  logic         inReady, oValid, keyEn, busyS;
  logic [127:0] oData;
  logic [3:0]   keyAddr, roundS;
  assign inReady = useBig ? ir14 : ir10;
  assign oValid  = useBig ? ov14 : ov10;
  assign oData   = useBig ? od14 : od10;
  assign keyEn   = useBig ? kr14 : kr10;
  assign keyAddr = useBig ? ka14 : ka10;
  assign busyS   = useBig ? busy14 : busy10;
  assign roundS  = useBig ? rd14 : rd10;

  aes_decrypt_ctrl #(.NR(10), .KEY_AW(4)) dut10 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv10), .in_ready(ir10), .in_data(inData),
    .out_valid(ov10), .out_ready(outReady), .out_data(od10), .key_rd_en(kr10),
    .key_addr(ka10), .key_data(kd10), .busy(busy10), .round(rd10));

  aes_decrypt_ctrl #(.NR(14), .KEY_AW(4)) dut14 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv14), .in_ready(ir14), .in_data(inData),
    .out_valid(ov14), .out_ready(outReady), .out_data(od14), .key_rd_en(kr14),
    .key_addr(ka14), .key_data(kd14), .busy(busy14), .round(rd14));

  logic [127:0] rk10 [0:10];
  logic [127:0] rk14 [0:14];
  logic [31:0]  w [0:59];

  // Round-key stores with one-cycle synchronous read.
  always @(posedge clk) begin
    if (kr10) kd10 <= rk10[ka10];
    if (kr14) kd14 <= rk14[ka14];
  end

  logic [7:0] sbox [256];
  logic [7:0] invSb [256];
  logic [7:0] expT [256];
  int         logT [256];

  int checks = 0;
  int passes = 0;

  localparam logic [127:0] PT_REF = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return expT[(logT[a] + logT[b]) % 255];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // S-box from the multiply-by-3 / divide-by-3 walk, with exp/log tables as a by-product.
  task automatic buildTables();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    expT[0] = 8'h01; logT[1] = 0;
    for (int k = 1; k < 256; k++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
      if (k < 255) begin expT[k] = p; logT[p] = k; end
    end
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) invSb[sbox[i]] = 8'(i);
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic expandKey(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] refDecrypt(input logic [127:0] ct, input bit big);
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk, pt;
    int nr;
    nr = big ? 14 : 10;
    rk = big ? rk14[nr] : rk10[nr];
    for (int i = 0; i < 16; i++) st[i] = ct[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int r = nr - 1; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) tmp[4*((c+row)%4)+row] = st[4*c+row];
      rk = big ? rk14[r] : rk10[r];
      for (int i = 0; i < 16; i++) st[i] = invSb[tmp[i]] ^ rk[127-8*i -: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = gm(a0, 8'd14) ^ gm(a1, 8'd11) ^ gm(a2, 8'd13) ^ gm(a3, 8'd9);
          st[4*c+1] = gm(a0, 8'd9)  ^ gm(a1, 8'd14) ^ gm(a2, 8'd11) ^ gm(a3, 8'd13);
          st[4*c+2] = gm(a0, 8'd13) ^ gm(a1, 8'd9)  ^ gm(a2, 8'd14) ^ gm(a3, 8'd11);
          st[4*c+3] = gm(a0, 8'd11) ^ gm(a1, 8'd13) ^ gm(a2, 8'd9)  ^ gm(a3, 8'd14);
        end
      end
    end
    for (int i = 0; i < 16; i++) pt[127-8*i -: 8] = st[i];
    return pt;
  endfunction

  // Pushes one block through the selected instance; checks latency, key order and busy behaviour.
  task automatic runBlock(input logic [127:0] ct, input int stall, input bit noise,
                          output logic [127:0] res);
    logic [63:0]  logEn;
    int           logAd [64];
    int           c, lat, nr, badCyc;
    bit           readyOk, stableOk, keyOk;
    logic [127:0] held;
    nr = useBig ? 14 : 10;
    readyOk = 1; stableOk = 1; keyOk = 1; badCyc = -1;
    logEn = '0;
    @(negedge clk); inValid = 1'b1; inData = ct; outReady = 1'b0; #1;
    checks++;
    if (inReady !== 1'b1) $display("FAIL accept_ready: in_ready=%b required 1", inReady);
    else passes++;
    logEn[0] = keyEn; logAd[0] = int'(keyAddr);
    c = 0; lat = -1;
    while (lat < 0 && c < 40) begin
      @(negedge clk); c++;
      inValid = noise; inData = noise ? rand128() : ct;
      #1;
      logEn[c] = keyEn; logAd[c] = int'(keyAddr);
      if (inReady !== 1'b0 || busyS !== 1'b1) readyOk = 0;
      if (oValid === 1'b1) lat = c;
    end
    checks++;
    if (lat != nr + 2) $display("FAIL latency: out_valid after %0d cycles required %0d", lat, nr + 2);
    else passes++;
    checks++;
    if (!readyOk) $display("FAIL busy_in_ready: in_ready/busy wrong while busy (in_ready=%b busy=%b)", inReady, busyS);
    else passes++;
    for (int k = 0; k <= c; k++) begin
      if (logEn[k] !== (k <= nr) || (k <= nr && logAd[k] != nr - k)) begin
        if (keyOk) badCyc = k;
        keyOk = 0;
      end
    end
    checks++;
    if (!keyOk) $display("FAIL key_seq: cycle %0d key_rd_en=%b key_addr=%0d required en=%0d addr=%0d",
                         badCyc, logEn[badCyc], logAd[badCyc], badCyc <= nr, nr - badCyc);
    else passes++;
    held = oData;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); inValid = noise; inData = noise ? rand128() : ct; #1;
      if (oValid !== 1'b1 || oData !== held || inReady !== 1'b0 || busyS !== 1'b1) stableOk = 0;
    end
    if (stall > 0) begin
      checks++;
      if (!stableOk) $display("FAIL backpressure_hold: out_valid=%b out_data=%h required 1/%h", oValid, oData, held);
      else passes++;
    end
    res = held;
    @(negedge clk); inValid = 1'b0; outReady = 1'b1; #1;
    @(negedge clk); outReady = 1'b0; #1;
    checks++;
    if (inReady !== 1'b1 || oValid !== 1'b0)
      $display("FAIL post_handshake: in_ready=%b out_valid=%b required 1/0", inReady, oValid);
    else passes++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; inValid = 1'b1; inData = rand128(); outReady = 1'b0; useBig = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (inReady !== 1'b0 || keyEn !== 1'b0)
      $display("FAIL reset_hold: in_ready=%b key_rd_en=%b required 0/0", inReady, keyEn);
    else passes++;
    @(negedge clk); inValid = 1'b0; reset_n = 1'b1; #1;
    checks++;
    if ({oValid, keyEn, busyS, inReady} !== 4'b0001)
      $display("FAIL reset_ctrl: out_valid=%b key_rd_en=%b busy=%b in_ready=%b required 0001", oValid, keyEn, busyS, inReady);
    else passes++;
    checks++;
    if (oData !== 128'h0) $display("FAIL reset_data: out_data=%h required 0", oData);
    else passes++;
    checks++;
    if (keyAddr !== 4'd0 || roundS !== 4'd0)
      $display("FAIL reset_counters: key_addr=%0d round=%0d required 0/0", keyAddr, roundS);
    else passes++;
    checks++;
    if ({ov14, kr14, busy14, od14, rd14} !== '0)
      $display("FAIL reset_nr14: out_valid=%b key_rd_en=%b busy=%b round=%0d required zeros", ov14, kr14, busy14, rd14);
    else passes++;
  endtask

  task automatic test_fips_c1();
    logic [127:0] res;
    runBlock(C1_CT, 0, 1'b0, res);
    checks++;
    if (res !== PT_REF) $display("FAIL c1_plaintext: got %h required %h", res, PT_REF);
    else passes++;
    $display("c1 block: ct=%h pt=%h", C1_CT, res);
  endtask

  task automatic test_backpressure();
    logic [127:0] ct, res, exp;
    ct = rand128(); exp = refDecrypt(ct, 1'b0);
    runBlock(ct, 5, 1'b0, res);
    checks++;
    if (res !== exp) $display("FAIL backpressure_data: got %h required %h", res, exp);
    else passes++;
    $display("backpressure block: ct=%h pt=%h", ct, res);
  endtask

  task automatic test_busy_reject();
    logic [127:0] ct, res, exp;
    ct = rand128(); exp = refDecrypt(ct, 1'b0);
    runBlock(ct, 2, 1'b1, res);
    checks++;
    if (res !== exp) $display("FAIL busy_reject_data: got %h required %h", res, exp);
    else passes++;
    $display("busy-reject block: ct=%h pt=%h", ct, res);
  endtask

  task automatic test_back_to_back();
    logic [127:0] ct [2];
    logic [127:0] got [2];
    int acc [2];
    int c, na, nd;
    ct[0] = rand128(); ct[1] = rand128();
    acc[0] = 0; acc[1] = 0; got[0] = '0; got[1] = '0;
    c = 0; na = 0; nd = 0;
    @(negedge clk); inValid = 1'b1; inData = ct[0]; outReady = 1'b1;
    while (nd < 2 && c < 60) begin
      #1;
      if (inValid && inReady && na < 2) begin acc[na] = c; na++; end
      if (oValid === 1'b1 && nd < 2) begin got[nd] = oData; nd++; end
      @(negedge clk); c++;
      if (na == 1) inData = ct[1];
      if (na >= 2) inValid = 1'b0;
    end
    inValid = 1'b0; outReady = 1'b0;
    checks++;
    if (na != 2 || acc[1] - acc[0] != 13)
      $display("FAIL b2b_spacing: accepts=%0d gap=%0d required 2 accepts 13 apart", na, acc[1] - acc[0]);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got[i] !== refDecrypt(ct[i], 1'b0))
        $display("FAIL b2b_data%0d: got %h required %h", i, got[i], refDecrypt(ct[i], 1'b0));
      else passes++;
      $display("b2b block %0d: ct=%h pt=%h", i, ct[i], got[i]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [127:0] res;
    int  c;
    bit  leaked;
    @(negedge clk); inValid = 1'b1; inData = rand128(); #1;
    @(negedge clk); inValid = 1'b0; #1;
    c = 0;
    while (roundS !== 4'd5 && c < 20) begin @(negedge clk); #1; c++; end
    checks++;
    if (roundS !== 4'd5 || busyS !== 1'b1) $display("FAIL reset_mid_reach: round=%0d busy=%b required 5/1", roundS, busyS);
    else passes++;
    reset_n = 1'b0; #1;
    checks++;
    if (keyEn !== 1'b0) $display("FAIL reset_mid_no_read: key_rd_en=%b required 0", keyEn);
    else passes++;
    @(negedge clk); reset_n = 1'b1; #1;
    checks++;
    if ({busyS, oValid, keyEn, inReady} !== 4'b0001 || roundS !== 4'd0 || oData !== 128'h0)
      $display("FAIL reset_mid_state: busy=%b out_valid=%b key_rd_en=%b in_ready=%b round=%0d out_data=%h",
               busyS, oValid, keyEn, inReady, roundS, oData);
    else passes++;
    leaked = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      if (oValid !== 1'b0 || busyS !== 1'b0) leaked = 1;
    end
    checks++;
    if (leaked) $display("FAIL reset_mid_leak: out_valid/busy rose after reset (out_valid=%b busy=%b)", oValid, busyS);
    else passes++;
    runBlock(C1_CT, 0, 1'b0, res);
    checks++;
    if (res !== PT_REF) $display("FAIL reset_mid_c1: got %h required %h", res, PT_REF);
    else passes++;
    $display("post-reset c1 block: pt=%h", res);
  endtask

  task automatic test_random();
    logic [127:0] ct, res, exp;
    for (int i = 0; i < 4; i++) begin
      ct = rand128(); exp = refDecrypt(ct, 1'b0);
      runBlock(ct, int'($urandom_range(0, 2)), 1'b0, res);
      checks++;
      if (res !== exp) $display("FAIL random%0d: got %h required %h", i, res, exp);
      else passes++;
      $display("random block %0d: ct=%h pt=%h", i, ct, res);
    end
  endtask

  task automatic test_nr14();
    logic [127:0] ct, res, exp;
    useBig = 1'b1;
    @(negedge clk);
    runBlock(C3_CT, 0, 1'b0, res);
    checks++;
    if (res !== PT_REF) $display("FAIL c3_plaintext: got %h required %h", res, PT_REF);
    else passes++;
    $display("c3 block: ct=%h pt=%h", C3_CT, res);
    for (int i = 0; i < 2; i++) begin
      ct = rand128(); exp = refDecrypt(ct, 1'b1);
      runBlock(ct, 1, 1'b0, res);
      checks++;
      if (res !== exp) $display("FAIL nr14_random%0d: got %h required %h", i, res, exp);
      else passes++;
      $display("nr14 random block %0d: ct=%h pt=%h", i, ct, res);
    end
    useBig = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; inValid = 1'b0; outReady = 1'b0; useBig = 1'b0; inData = '0;
    kd10 = '0; kd14 = '0;
    buildTables();
    expandKey({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    for (int r = 0; r <= 10; r++) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    expandKey(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    for (int r = 0; r <= 14; r++) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    test_reset();
    test_fips_c1();
    test_backpressure();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_nr14();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
